// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// default reset vector and the target alignment helper.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    PEND = 2'd3
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Fetch addresses are word aligned, so the low two bits of any target are dropped.
  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/stall inputs and fetch outputs of the PC sequencer.
// The slave side is the sequencer; the master side is the pipeline driving it.
interface pc_sequencer_if;

  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] PCResult;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        FlushIFID;

  modport master (
    output Stall, BranchTaken, BranchTarget, JumpReg, JumpRegTarget, Jump, JumpTarget,
    input  PCResult, PCPlus4, FetchValid, FlushIFID
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, JumpReg, JumpRegTarget, Jump, JumpTarget,
    output PCResult, PCPlus4, FetchValid, FlushIFID
  );

endinterface

// File: rtl/pc_next_mux.sv
// Priority redirect select (branch > jr > j) with word alignment of the
// chosen target; purely combinational.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] target
);

  assign redirect = branch_taken | jump_reg | jump;

  // EX-stage redirects are older than the ID-stage jump, so they win.
  always_comb begin
    target = '0;
    if (branch_taken) begin
      target = align_target(branch_target);
    end else if (jump_reg) begin
      target = align_target(jump_reg_target);
    end else if (jump) begin
      target = align_target(jump_target);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with stall handling and a one-entry pending redirect
// that is replayed once a stall covering the redirect is released.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  pc_sequencer_if.slave bus
);

  pc_state_t   state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pend_reg;
  logic        fetch_valid_reg;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        flush;

  pc_next_mux u_next_mux (
    .branch_taken    (bus.BranchTaken),
    .branch_target   (bus.BranchTarget),
    .jump_reg        (bus.JumpReg),
    .jump_reg_target (bus.JumpRegTarget),
    .jump            (bus.Jump),
    .jump_target     (bus.JumpTarget),
    .redirect        (redirect),
    .target          (target)
  );

  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_reg          <= RESET_VECTOR;
      pend_reg        <= '0;
      state_reg       <= BOOT;
      fetch_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg       <= RUN;
          fetch_valid_reg <= 1'b1;
        end
        RUN, HOLD: begin
          if (!bus.Stall) begin
            pc_reg          <= redirect ? target : pc_plus4;
            state_reg       <= RUN;
            fetch_valid_reg <= 1'b1;
          end else if (redirect) begin
            // Redirect arrived while stalled: park it until the stall clears.
            pend_reg        <= target;
            state_reg       <= PEND;
            fetch_valid_reg <= 1'b0;
          end else begin
            state_reg       <= HOLD;
            fetch_valid_reg <= 1'b1;
          end
        end
        PEND: begin
          // Anything presented now is on the wrong path behind the parked redirect.
          if (!bus.Stall) begin
            pc_reg          <= pend_reg;
            state_reg       <= RUN;
            fetch_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg       <= BOOT;
          fetch_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    flush = 1'b0;
    if (Reset && !bus.Stall) begin
      case (state_reg)
        RUN, HOLD: flush = redirect;
        PEND:      flush = 1'b1;
        default:   flush = 1'b0;
      endcase
    end
  end

  assign bus.PCResult   = pc_reg;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.FetchValid = fetch_valid_reg & Reset;
  assign bus.FlushIFID  = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected fetch state is queued per cycle
// and popped/compared against the DUT at the falling edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
  } exp_t;

  exp_t sb[$];

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input string       tag,
    input logic        rst,
    input logic        stl,
    input logic        bt,
    input logic [31:0] btt,
    input logic        jr,
    input logic [31:0] jrt,
    input logic        j,
    input logic [31:0] jt,
    input logic [31:0] e_pc,
    input logic        e_fv,
    input logic        e_fl
  );
    exp_t e;
    exp_t pushed;
    logic [31:0] e_p4;
    reset             = rst;
    bus.Stall         = stl;
    bus.BranchTaken   = bt;
    bus.BranchTarget  = btt;
    bus.JumpReg       = jr;
    bus.JumpRegTarget = jrt;
    bus.Jump          = j;
    bus.JumpTarget    = jt;
    pushed.pc = e_pc;
    pushed.fv = e_fv;
    pushed.fl = e_fl;
    sb.push_back(pushed);
    @(negedge clk);
    e = sb.pop_front();
    e_p4 = e.pc + 32'd4;
    checks++;
    assert (bus.PCResult === e.pc) else begin
      failures++;
      $error("FAIL %s pc observed=%h expected=%h", tag, bus.PCResult, e.pc);
    end
    checks++;
    assert (bus.PCPlus4 === e_p4) else begin
      failures++;
      $error("FAIL %s pcplus4 observed=%h expected=%h", tag, bus.PCPlus4, e_p4);
    end
    checks++;
    assert (bus.FetchValid === e.fv) else begin
      failures++;
      $error("FAIL %s fetchvalid observed=%b expected=%b", tag, bus.FetchValid, e.fv);
    end
    checks++;
    assert (bus.FlushIFID === e.fl) else begin
      failures++;
      $error("FAIL %s flush observed=%b expected=%b", tag, bus.FlushIFID, e.fl);
    end
    $display("step %-10s pc=%h fv=%b fl=%b", tag, bus.PCResult, bus.FetchValid, bus.FlushIFID);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RV = RESET_VECTOR_DEFAULT;

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    bus.Stall = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = '0;
    bus.JumpReg = 1'b0;
    bus.JumpRegTarget = '0;
    bus.Jump = 1'b0;
    bus.JumpTarget = '0;
    @(posedge clk);
    #1;
    //        tag           rst  stl  bt   btt            jr   jrt           j    jt            e_pc           fv   fl
    step("rst0",         0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   RV,            0, 0);
    step("rst1_redir",   0, 0, 1, 32'h44,       0, 32'h0,   0, 32'h0,   RV,            0, 0);
    step("boot",         1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
    step("run0",         1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,         1, 0);
    step("run4",         1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h4,         1, 0);
    step("run8",         1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h8,         1, 0);
    step("run12",        1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'hC,         1, 0);
    step("stl_jmp",      1, 1, 0, 32'h0,        0, 32'h0,   1, 32'h103, 32'h10,        1, 0);
    step("pend_br",      1, 1, 1, 32'h200,      0, 32'h0,   0, 32'h0,   32'h10,        0, 0);
    step("pend_stl",     1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h10,        0, 0);
    step("pend_rel",     1, 0, 1, 32'h300,      0, 32'h0,   0, 32'h0,   32'h10,        0, 1);
    step("at100_br8",    1, 0, 1, 32'h8,        0, 32'h0,   0, 32'h0,   32'h100,       1, 1);
    step("br_vs_jr",     1, 0, 1, 32'h40,       1, 32'h80,  0, 32'h0,   32'h8,         1, 1);
    step("jr_vs_j",      1, 0, 0, 32'h0,        1, 32'h24,  1, 32'h13,  32'h40,        1, 1);
    step("j_align",      1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h17,  32'h24,        1, 1);
    step("hold20_a",     1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h14,        1, 0);
    step("hold20_b",     1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h14,        1, 0);
    step("hold20_rel",   1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h14,        1, 0);
    step("run24_stl",    1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h18,        1, 0);
    step("hold_br",      1, 0, 1, 32'hFFFFFFFF, 0, 32'h0,   0, 32'h0,   32'h18,        1, 1);
    step("wrap",         1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'hFFFFFFFC,  1, 0);
    step("wrapped",      1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,         1, 0);
    step("stl_at4",      1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h4,         1, 0);
    step("hold_jr",      1, 1, 0, 32'h0,        1, 32'h100, 0, 32'h0,   32'h4,         1, 0);
    step("pend2",        1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h4,         0, 0);
    step("rst_pend",     0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h4,         0, 0);
    step("boot2",        1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   RV,            0, 0);
    step("run0_b",       1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   RV,            1, 0);
    step("run4_b",       1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   RV + 32'h4,    1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
